// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port RAM: port A pushes, port B pops.
// Optional sticky overflow/underflow error flags are enabled by defining DPRAM_FIFO_ERR_EN.
module dpram_fifo_ctrl #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 4,
    parameter int unsigned AFULL_TH = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          full,
    output logic          almost_full,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ram_wr_enA,
    output logic [AW-1:0] ram_addr_A,
    output logic [DW-1:0] ram_wr_dataA,
    output logic          ram_wr_enB,
    output logic [AW-1:0] ram_addr_B,
`ifdef DPRAM_FIFO_ERR_EN
    output logic          ovf_err,
    output logic          udf_err,
    input  logic          err_clr,
`endif
    input  logic [DW-1:0] ram_rd_dataB
);

    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_q;
    logic [PW-1:0] count_nxt;
    logic          empty_q;
    logic          full_q;
    logic          afull_q;
    logic          pop_valid_q;
    logic [DW-1:0] hold_q;
    logic          push_acc;
    logic          pop_acc;

    // Acceptance is qualified only by the registered flags, never by the other request.
    assign push_acc = push & ~full_q;
    assign pop_acc  = pop & ~empty_q;

    assign ram_wr_enA   = push_acc;
    assign ram_addr_A   = wr_ptr[AW-1:0];
    assign ram_wr_dataA = push_data;
    assign ram_wr_enB   = 1'b0;
    assign ram_addr_B   = rd_ptr[AW-1:0];

    always_comb begin
        count_nxt = count_q;
        if (push_acc && !pop_acc) begin
            count_nxt = count_q + PW'(1);
        end else if (pop_acc && !push_acc) begin
            count_nxt = count_q - PW'(1);
        end
    end

    // Pointers carry one wrap bit beyond the RAM address width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Flags are registered from the next occupancy, so they move with the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == PW'(DEPTH));
            afull_q <= (count_nxt >= PW'(AFULL_TH));
        end
    end

    // RAM read data lands one cycle after the accepted pop; keep the last word afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            pop_valid_q <= pop_acc;
            if (pop_valid_q) begin
                hold_q <= ram_rd_dataB;
            end
        end
    end

    assign pop_data    = pop_valid_q ? ram_rd_dataB : hold_q;
    assign pop_valid   = pop_valid_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign count       = count_q;

`ifdef DPRAM_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags; a new set condition beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= (push & full_q) | (ovf_q & ~err_clr);
            udf_q <= (pop & empty_q) | (udf_q & ~err_clr);
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 16x8 dual-port RAM attached.
module tb_dpram_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic [7:0] push_data;
    logic       full;
    logic       almost_full;
    logic       pop;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       empty;
    logic [4:0] count;
    logic       ram_wr_enA;
    logic [3:0] ram_addr_A;
    logic [7:0] ram_wr_dataA;
    logic       ram_wr_enB;
    logic [3:0] ram_addr_B;
    logic [7:0] ram_rd_dataB;
`ifdef DPRAM_FIFO_ERR_EN
    logic       ovf_err;
    logic       udf_err;
    logic       err_clr;
`endif

    int checks = 0;
    int errors = 0;

    dpram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_data    (push_data),
        .full         (full),
        .almost_full  (almost_full),
        .pop          (pop),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .empty        (empty),
        .count        (count),
        .ram_wr_enA   (ram_wr_enA),
        .ram_addr_A   (ram_addr_A),
        .ram_wr_dataA (ram_wr_dataA),
        .ram_wr_enB   (ram_wr_enB),
        .ram_addr_B   (ram_addr_B),
`ifdef DPRAM_FIFO_ERR_EN
        .ovf_err      (ovf_err),
        .udf_err      (udf_err),
        .err_clr      (err_clr),
`endif
        .ram_rd_dataB (ram_rd_dataB)
    );

    // Behavioural RAM: registered write on A, registered read on B.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_wr_enA) mem[ram_addr_A] <= ram_wr_dataA;
        if (ram_wr_enB) mem[ram_addr_B] <= 8'h00;
        ram_rd_dataB <= mem[ram_addr_B];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p, input logic [7:0] d, input logic q);
        push = p;
        push_data = d;
        pop = q;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        push = 1'b0;
        push_data = 8'h00;
        pop = 1'b0;
`ifdef DPRAM_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        tick;
        tick;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_pop_valid", 32'(pop_valid), 0);
        chk("rst_pop_data", 32'(pop_data), 0);
        chk("rst_ram_outs", {ram_wr_enA, ram_addr_A, ram_wr_dataA, ram_wr_enB, ram_addr_B}, 0);
        rst_n = 1'b1;
        tick;

        // Two pushes then two pops
        drive(1, 8'hAA, 0);
        chk("t1_wr_enA", 32'(ram_wr_enA), 1);
        chk("t1_addr_A", 32'(ram_addr_A), 0);
        tick;
        chk("t1_count1", 32'(count), 1);
        chk("t1_not_empty", 32'(empty), 0);
        drive(1, 8'hBB, 0);
        tick;
        chk("t1_count2", 32'(count), 2);
        drive(0, 8'h00, 1);
        tick;
        chk("t1_count_pop1", 32'(count), 1);
        chk("t1_pv1", 32'(pop_valid), 1);
        chk("t1_pd1", 32'(pop_data), 32'hAA);
        drive(0, 8'h00, 1);
        tick;
        chk("t1_count_pop2", 32'(count), 0);
        chk("t1_pv2", 32'(pop_valid), 1);
        chk("t1_pd2", 32'(pop_data), 32'hBB);
        chk("t1_empty", 32'(empty), 1);
        drive(0, 8'h00, 0);
        tick;
        chk("t1_pv_low", 32'(pop_valid), 0);
        chk("t1_hold", 32'(pop_data), 32'hBB);

        // Fill to 16, thresholds, dropped 17th push
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(i), 0);
            tick;
            if (i == 12) chk("t2_afull_13", 32'(almost_full), 0);
            if (i == 13) chk("t2_afull_14", 32'(almost_full), 1);
            if (i == 14) chk("t2_full_15", 32'(full), 0);
        end
        chk("t2_count16", 32'(count), 16);
        chk("t2_full", 32'(full), 1);
        drive(1, 8'hFF, 0);
        chk("t2_drop_wr_enA", 32'(ram_wr_enA), 0);
        tick;
        chk("t2_count_stay", 32'(count), 16);
`ifdef DPRAM_FIFO_ERR_EN
        chk("t2_ovf_err", 32'(ovf_err), 1);
        err_clr = 1'b1;
        drive(0, 8'h00, 0);
        tick;
        err_clr = 1'b0;
        chk("t2_ovf_clr", 32'(ovf_err), 0);
`endif

        // Full with simultaneous push and pop
        drive(1, 8'h55, 1);
        chk("t3_no_collision", 32'(ram_wr_enA && (ram_addr_A == ram_addr_B)), 0);
        chk("t3_wr_enA", 32'(ram_wr_enA), 0);
        tick;
        chk("t3_count15", 32'(count), 15);
        chk("t3_pv", 32'(pop_valid), 1);
        chk("t3_pd", 32'(pop_data), 32'h00);
        chk("t3_not_full", 32'(full), 0);
        for (int i = 1; i < 16; i++) begin
            drive(0, 8'h00, 1);
            tick;
            chk("t3_drain", 32'(pop_data), 32'(i));
        end
        chk("t3_empty", 32'(empty), 1);
        drive(0, 8'h00, 0);
        tick;

        // Empty with simultaneous push and pop
        drive(1, 8'h66, 1);
        tick;
        chk("t4_count1", 32'(count), 1);
        chk("t4_no_pv", 32'(pop_valid), 0);
`ifdef DPRAM_FIFO_ERR_EN
        chk("t4_udf_err", 32'(udf_err), 1);
`endif
        drive(0, 8'h00, 1);
        tick;
        chk("t4_pv", 32'(pop_valid), 1);
        chk("t4_pd", 32'(pop_data), 32'h66);
        chk("t4_count0", 32'(count), 0);

        // Wrap-around at steady occupancy 3
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'hC0 + i), 0);
            tick;
        end
        for (int k = 0; k < 20; k++) begin
            drive(1, 8'(8'hC3 + k), 1);
            tick;
            chk("t5_count3", 32'(count), 3);
            chk("t5_order", 32'(pop_data), 32'(8'hC0 + k));
        end

        // Reset mid-stream with count 5 and pop_valid pending
        drive(1, 8'hD0, 0);
        tick;
        drive(1, 8'hD1, 0);
        tick;
        drive(1, 8'hD2, 1);
        tick;
        chk("t6_pre_count5", 32'(count), 5);
        chk("t6_pre_pv", 32'(pop_valid), 1);
        drive(0, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_count0", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_pv0", 32'(pop_valid), 0);
        chk("t6_pd0", 32'(pop_data), 0);
        #2;
        rst_n = 1'b1;
        tick;
        drive(1, 8'h77, 0);
        tick;
        drive(0, 8'h00, 1);
        tick;
        chk("t6_pv", 32'(pop_valid), 1);
        chk("t6_pd", 32'(pop_data), 32'h77);
        drive(0, 8'h00, 0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
